// File: rtl/axis_header_extractor.sv
// AXIS tap: forwards every beat through a two-entry registered skid buffer while capturing
// each packet's leading header beats and reporting its saturating byte length at packet end.
module axis_header_extractor #(
    parameter int unsigned TDATA_WIDTH  = 64,
    parameter int unsigned TUSER_WIDTH  = 128,
    parameter int unsigned HEADER_BEATS = 2,
    parameter int unsigned LEN_WIDTH    = 16
) (
    input  logic                                   axis_aclk,
    input  logic                                   axis_resetn,

    input  logic [TDATA_WIDTH-1:0]                 axis_resize_tdata,
    input  logic [TDATA_WIDTH/8-1:0]               axis_resize_tkeep,
    input  logic [TUSER_WIDTH-1:0]                 axis_resize_tuser,
    input  logic                                   axis_resize_tvalid,
    output logic                                   axis_resize_tready,
    input  logic                                   axis_resize_tlast,

    output logic [TDATA_WIDTH-1:0]                 axis_tap_tdata,
    output logic [TDATA_WIDTH/8-1:0]               axis_tap_tkeep,
    output logic [TUSER_WIDTH-1:0]                 axis_tap_tuser,
    output logic                                   axis_tap_tlast,
    output logic                                   axis_tap_tvalid,
    input  logic                                   axis_tap_tready,

    output logic [HEADER_BEATS*TDATA_WIDTH-1:0]    header_tdata,
    output logic [HEADER_BEATS*TDATA_WIDTH/8-1:0]  header_tkeep,
    output logic [TUSER_WIDTH-1:0]                 header_tuser,
    output logic                                   header_short,
    output logic                                   header_valid,
    output logic [LEN_WIDTH-1:0]                   pkt_len,
    output logic                                   pkt_len_valid
);

    localparam int unsigned KeepW = TDATA_WIDTH / 8;
    localparam int unsigned BeatW = TDATA_WIDTH + KeepW + TUSER_WIDTH + 1;
    localparam int unsigned HdrW  = HEADER_BEATS * TDATA_WIDTH;
    localparam int unsigned HdrKW = HEADER_BEATS * KeepW;
    localparam int unsigned CntW  = $clog2(HEADER_BEATS + 1);
    localparam int unsigned PopW  = $clog2(KeepW + 1);
    localparam int unsigned SumW  = ((LEN_WIDTH > PopW) ? LEN_WIDTH : PopW) + 1;
    localparam logic [LEN_WIDTH-1:0] LenMax = '1;

    typedef enum logic [1:0] {StIdle, StHeader, StPayload} state_e;

    // ---------------- skid buffer ----------------
    logic [BeatW-1:0] mem_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       cnt_q, cnt_d;
    logic             tready_q;
    logic             in_hs, out_hs;
    logic [BeatW-1:0] in_beat;

    assign in_hs   = axis_resize_tvalid & tready_q;
    assign out_hs  = axis_tap_tvalid & axis_tap_tready;
    assign in_beat = {axis_resize_tuser, axis_resize_tlast, axis_resize_tkeep, axis_resize_tdata};

    always_comb begin
        cnt_d = cnt_q + 2'(in_hs) - 2'(out_hs);
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
            tready_q <= 1'b0;
        end else begin
            if (in_hs) begin
                mem_q[wr_ptr_q] <= in_beat;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (out_hs) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q    <= cnt_d;
            // Ready reflects next-cycle occupancy so it never needs a combinational path.
            tready_q <= (cnt_d != 2'd2);
        end
    end

    assign axis_resize_tready = tready_q;
    assign axis_tap_tvalid    = (cnt_q != 2'd0);
    assign {axis_tap_tuser, axis_tap_tlast, axis_tap_tkeep, axis_tap_tdata} = mem_q[rd_ptr_q];

    // ---------------- length accumulation ----------------
    logic [PopW-1:0]      pop;
    logic [SumW-1:0]      sum;
    logic [LEN_WIDTH-1:0] len_sat;
    logic [LEN_WIDTH-1:0] byte_cnt_q;

    always_comb begin
        pop = '0;
        for (int i = 0; i < KeepW; i++) begin
            pop = pop + PopW'(axis_resize_tkeep[i]);
        end
        sum     = SumW'(byte_cnt_q) + SumW'(pop);
        len_sat = (sum > SumW'(LenMax)) ? LenMax : sum[LEN_WIDTH-1:0];
    end

    // ---------------- header capture FSM ----------------
    state_e               state_q;
    logic [CntW-1:0]      beat_cnt_q;
    logic [HdrW-1:0]      header_tdata_q;
    logic [HdrKW-1:0]     header_tkeep_q;
    logic [TUSER_WIDTH-1:0] header_tuser_q;
    logic                 header_short_q;
    logic                 header_valid_q;
    logic [LEN_WIDTH-1:0] pkt_len_q;
    logic                 pkt_len_valid_q;

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q         <= StIdle;
            beat_cnt_q      <= '0;
            byte_cnt_q      <= '0;
            header_tdata_q  <= '0;
            header_tkeep_q  <= '0;
            header_tuser_q  <= '0;
            header_short_q  <= 1'b0;
            header_valid_q  <= 1'b0;
            pkt_len_q       <= '0;
            pkt_len_valid_q <= 1'b0;
        end else begin
            header_valid_q  <= 1'b0;
            pkt_len_valid_q <= 1'b0;
            if (in_hs) begin
                if (axis_resize_tlast) begin
                    pkt_len_q       <= len_sat;
                    pkt_len_valid_q <= 1'b1;
                    byte_cnt_q      <= '0;
                end else begin
                    byte_cnt_q      <= len_sat;
                end

                unique case (state_q)
                    StIdle: begin
                        header_tdata_q <= HdrW'(axis_resize_tdata);
                        header_tkeep_q <= HdrKW'(axis_resize_tkeep);
                        header_tuser_q <= axis_resize_tuser;
                        header_short_q <= 1'b0;
                        beat_cnt_q     <= CntW'(1);
                        if (axis_resize_tlast) begin
                            header_valid_q <= 1'b1;
                            header_short_q <= (HEADER_BEATS > 1);
                        end else if (HEADER_BEATS == 1) begin
                            header_valid_q <= 1'b1;
                            state_q        <= StPayload;
                        end else begin
                            state_q        <= StHeader;
                        end
                    end
                    StHeader: begin
                        for (int k = 1; k < HEADER_BEATS; k++) begin
                            if (beat_cnt_q == CntW'(k)) begin
                                header_tdata_q[k*TDATA_WIDTH +: TDATA_WIDTH] <= axis_resize_tdata;
                                header_tkeep_q[k*KeepW +: KeepW]             <= axis_resize_tkeep;
                            end
                        end
                        beat_cnt_q <= beat_cnt_q + CntW'(1);
                        if (beat_cnt_q == CntW'(HEADER_BEATS - 1)) begin
                            header_valid_q <= 1'b1;
                            state_q        <= axis_resize_tlast ? StIdle : StPayload;
                        end else if (axis_resize_tlast) begin
                            header_valid_q <= 1'b1;
                            header_short_q <= 1'b1;
                            state_q        <= StIdle;
                        end
                    end
                    StPayload: begin
                        if (axis_resize_tlast) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign header_tdata  = header_tdata_q;
    assign header_tkeep  = header_tkeep_q;
    assign header_tuser  = header_tuser_q;
    assign header_short  = header_short_q;
    assign header_valid  = header_valid_q;
    assign pkt_len       = pkt_len_q;
    assign pkt_len_valid = pkt_len_valid_q;

endmodule

// File: tb/tb_axis_header_extractor.sv
// Bench for axis_header_extractor: directed and random packets checked against a packet-level
// reference model (beat queue, header assembly, byte sums) for a 16-bit and an 8-bit length DUT.
module tb_axis_header_extractor;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int UW = 128;
    localparam int HB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] in_tdata = '0;
    logic [KW-1:0] in_tkeep = '0;
    logic [UW-1:0] in_tuser = '0;
    logic          in_tvalid = 1'b0;
    logic          in_tlast = 1'b0;
    logic          tap_tready = 1'b1;

    logic              rs_tready, tap_tlast, tap_tvalid, hdr_short, hdr_valid, pkt_len_valid;
    logic [DW-1:0]     tap_tdata;
    logic [KW-1:0]     tap_tkeep;
    logic [UW-1:0]     tap_tuser, hdr_tuser;
    logic [HB*DW-1:0]  hdr_tdata;
    logic [HB*KW-1:0]  hdr_tkeep;
    logic [15:0]       pkt_len;

    logic              s_rs_tready, s_tap_tlast, s_tap_tvalid, s_hdr_short, s_hdr_valid;
    logic              s_pkt_len_valid;
    logic [DW-1:0]     s_tap_tdata;
    logic [KW-1:0]     s_tap_tkeep;
    logic [UW-1:0]     s_tap_tuser, s_hdr_tuser;
    logic [HB*DW-1:0]  s_hdr_tdata;
    logic [HB*KW-1:0]  s_hdr_tkeep;
    logic [7:0]        s_pkt_len;

    axis_header_extractor #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .HEADER_BEATS(HB),
                            .LEN_WIDTH(16)) u_dut (
        .axis_aclk(clk), .axis_resetn(rst_n),
        .axis_resize_tdata(in_tdata), .axis_resize_tkeep(in_tkeep),
        .axis_resize_tuser(in_tuser), .axis_resize_tvalid(in_tvalid),
        .axis_resize_tready(rs_tready), .axis_resize_tlast(in_tlast),
        .axis_tap_tdata(tap_tdata), .axis_tap_tkeep(tap_tkeep), .axis_tap_tuser(tap_tuser),
        .axis_tap_tlast(tap_tlast), .axis_tap_tvalid(tap_tvalid), .axis_tap_tready(tap_tready),
        .header_tdata(hdr_tdata), .header_tkeep(hdr_tkeep), .header_tuser(hdr_tuser),
        .header_short(hdr_short), .header_valid(hdr_valid),
        .pkt_len(pkt_len), .pkt_len_valid(pkt_len_valid)
    );

    axis_header_extractor #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .HEADER_BEATS(HB),
                            .LEN_WIDTH(8)) u_dut_sat (
        .axis_aclk(clk), .axis_resetn(rst_n),
        .axis_resize_tdata(in_tdata), .axis_resize_tkeep(in_tkeep),
        .axis_resize_tuser(in_tuser), .axis_resize_tvalid(in_tvalid),
        .axis_resize_tready(s_rs_tready), .axis_resize_tlast(in_tlast),
        .axis_tap_tdata(s_tap_tdata), .axis_tap_tkeep(s_tap_tkeep), .axis_tap_tuser(s_tap_tuser),
        .axis_tap_tlast(s_tap_tlast), .axis_tap_tvalid(s_tap_tvalid), .axis_tap_tready(tap_tready),
        .header_tdata(s_hdr_tdata), .header_tkeep(s_hdr_tkeep), .header_tuser(s_hdr_tuser),
        .header_short(s_hdr_short), .header_valid(s_hdr_valid),
        .pkt_len(s_pkt_len), .pkt_len_valid(s_pkt_len_valid)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    beat_t            expq[$];
    int               m_cnt = 0;
    int               m_bytes = 0;
    logic [HB*DW-1:0] m_hd;
    logic [HB*KW-1:0] m_hk;
    logic [UW-1:0]    m_hu;
    logic             p_hv = 1'b0, p_lv = 1'b0, p_short = 1'b0;
    logic [HB*DW-1:0] p_hd;
    logic [HB*KW-1:0] p_hk;
    logic [UW-1:0]    p_hu;
    int               p_len = 0;
    logic [15:0]      held_len = '0;
    logic [7:0]       held_slen = '0;
    logic             hs_seen = 1'b0;

    // Observation log for directed checks
    int               hv_count = 0;
    logic [15:0]      last_len = '0;
    logic [7:0]       last_slen = '0;
    logic [HB*DW-1:0] last_hd;
    logic [HB*KW-1:0] last_hk;
    logic [UW-1:0]    last_hu;
    logic             last_short, last_both;
    logic             saw_stall = 1'b0;
    logic [15:0]      len_log[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            m_cnt = 0; m_bytes = 0;
            p_hv = 1'b0; p_lv = 1'b0;
            held_len = '0; held_slen = '0;
            hs_seen = 1'b0;
        end else begin
            chk("tap_tvalid", tap_tvalid, expq.size() > 0);
            chk("resize_tready", rs_tready, expq.size() < 2);
            if (!rs_tready) saw_stall = 1'b1;
            chk("header_valid", hdr_valid, p_hv);
            chk("sat_header_valid", s_hdr_valid, p_hv);
            if (p_hv) begin
                chk("header_tdata", hdr_tdata, p_hd);
                chk("header_tkeep", hdr_tkeep, p_hk);
                chk("header_tuser", hdr_tuser, p_hu);
                chk("header_short", hdr_short, p_short);
                hv_count++;
                last_hd = hdr_tdata; last_hk = hdr_tkeep; last_hu = hdr_tuser;
                last_short = hdr_short; last_both = pkt_len_valid;
            end
            chk("pkt_len_valid", pkt_len_valid, p_lv);
            chk("sat_pkt_len_valid", s_pkt_len_valid, p_lv);
            if (p_lv) begin
                held_len  = (p_len > 65535) ? 16'hFFFF : 16'(p_len);
                held_slen = (p_len > 255) ? 8'hFF : 8'(p_len);
            end
            chk("pkt_len", pkt_len, held_len);
            chk("sat_pkt_len", s_pkt_len, held_slen);
            if (p_lv) begin
                last_len = pkt_len; last_slen = s_pkt_len;
                len_log.push_back(pkt_len);
            end
            p_hv = 1'b0; p_lv = 1'b0;

            if (tap_tvalid && tap_tready) begin
                if (expq.size() == 0) begin
                    chk("tap_unexpected_beat", tap_tvalid, 1'b0);
                end else begin
                    beat_t b;
                    b = expq.pop_front();
                    chk("tap_beat", {tap_tdata, tap_tkeep, tap_tuser, tap_tlast}, b);
                end
            end

            hs_seen = in_tvalid && rs_tready;
            if (hs_seen) begin
                expq.push_back('{d: in_tdata, k: in_tkeep, u: in_tuser, l: in_tlast});
                if (m_cnt == 0) begin
                    m_hd = '0; m_hk = '0; m_hu = in_tuser;
                end
                if (m_cnt < HB) begin
                    m_hd[m_cnt*DW +: DW] = in_tdata;
                    m_hk[m_cnt*KW +: KW] = in_tkeep;
                end
                m_cnt++;
                m_bytes += $countones(in_tkeep);
                if (m_cnt == HB || (in_tlast && m_cnt < HB)) begin
                    p_hv = 1'b1; p_hd = m_hd; p_hk = m_hk; p_hu = m_hu;
                    p_short = (m_cnt < HB);
                end
                if (in_tlast) begin
                    p_lv = 1'b1; p_len = m_bytes;
                    m_cnt = 0; m_bytes = 0;
                end
            end
        end
    end

    // Tap backpressure: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1
    int tap_mode = 0;
    int tap_ph = 0;
    always @(posedge clk) begin
        #1;
        case (tap_mode)
            0:       tap_tready = 1'b1;
            1:       tap_tready = 1'($urandom_range(0, 1));
            default: begin
                tap_tready = (tap_ph % 4 == 0) || (tap_ph % 4 == 3);
                tap_ph++;
            end
        endcase
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k,
                        input logic [UW-1:0] u, input logic l);
        int t;
        in_tdata = d; in_tkeep = k; in_tuser = u; in_tlast = l; in_tvalid = 1'b1;
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!hs_seen && t < 200);
        if (!hs_seen) chk("send_timeout", hs_seen, 1'b1);
        in_tvalid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (expq.size() != 0 && t < 200) begin
            idle(1);
            t++;
        end
        idle(2);
        chk("drain_empty", expq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int hv0, nb, n;
        logic [KW-1:0] k;

        // Reset state
        idle(3);
        chk("rst_tready", rs_tready, 1'b0);
        chk("rst_tap_tvalid", tap_tvalid, 1'b0);
        chk("rst_tap_tdata", tap_tdata, '0);
        chk("rst_header_tdata", hdr_tdata, '0);
        chk("rst_header_valid", hdr_valid, 1'b0);
        chk("rst_pkt_len", pkt_len, '0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("tready_after_release", rs_tready, 1'b1);

        // 3-beat packet
        send(64'h1111111111111111, 8'hFF, 128'hAB, 1'b0);
        send(64'h2222222222222222, 8'hFF, 128'h0, 1'b0);
        send(64'h3333333333333333, 8'h0F, 128'h0, 1'b1);
        drain();
        chk("t1_pkt_len", last_len, 16'd20);
        chk("t1_header_tdata", last_hd, {64'h2222222222222222, 64'h1111111111111111});
        chk("t1_header_tkeep", last_hk, 16'hFFFF);
        chk("t1_header_tuser", last_hu, 128'hAB);
        chk("t1_header_short", last_short, 1'b0);

        // 1-beat short packet
        send(64'h0000000000C0FFEE, 8'h07, 128'h5, 1'b1);
        drain();
        chk("t2_same_cycle", last_both, 1'b1);
        chk("t2_header_short", last_short, 1'b1);
        chk("t2_header_tkeep", last_hk, 16'h0007);
        chk("t2_pkt_len", last_len, 16'd3);

        // Tap backpressure during a 6-beat packet
        tap_mode = 2; tap_ph = 0; saw_stall = 1'b0;
        for (int i = 0; i < 6; i++) send(64'(i + 1), 8'hFF, 128'h0, i == 5);
        drain();
        tap_mode = 0;
        chk("t3_pkt_len", last_len, 16'd48);
        chk("t3_saw_stall", saw_stall, 1'b1);

        // Back-to-back 2- and 4-beat packets
        hv0 = hv_count;
        len_log.delete();
        send(64'hA0, 8'hFF, 128'h1, 1'b0);
        send(64'hA1, 8'hFF, 128'h0, 1'b1);
        for (int i = 0; i < 4; i++) send(64'hB0 + 64'(i), 8'hFF, (i == 0) ? 128'h2 : 128'h0, i == 3);
        drain();
        chk("t4_header_pulses", hv_count - hv0, 2);
        chk("t4_len_count", len_log.size(), 2);
        if (len_log.size() == 2) begin
            chk("t4_len_first", len_log[0], 16'd16);
            chk("t4_len_second", len_log[1], 16'd32);
        end
        chk("t4_header_tuser", last_hu, 128'h2);

        // 40-beat full packet saturates the 8-bit length
        for (int i = 0; i < 40; i++) send({$urandom, $urandom}, 8'hFF, 128'h0, i == 39);
        drain();
        chk("t5_sat_len", last_slen, 8'd255);
        chk("t5_full_len", last_len, 16'd320);

        // Asynchronous reset during beat 1
        send(64'hDEAD0000, 8'hFF, 128'h7, 1'b0);
        in_tdata = 64'hDEAD0001; in_tvalid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_tap_tvalid", tap_tvalid, 1'b0);
        chk("t6_tap_tdata", tap_tdata, '0);
        chk("t6_tready", rs_tready, 1'b0);
        chk("t6_header_tdata", hdr_tdata, '0);
        chk("t6_header_tuser", hdr_tuser, '0);
        chk("t6_pkt_len", pkt_len, '0);
        in_tvalid = 1'b0;
        idle(2);
        @(negedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        hv0 = hv_count;
        send(64'h5555, 8'hFF, 128'h9, 1'b0);
        send(64'h6666, 8'hFF, 128'h0, 1'b1);
        drain();
        chk("t6_header_pulses", hv_count - hv0, 1);
        chk("t6_header_tdata_new", last_hd, {64'h6666, 64'h5555});
        chk("t6_header_tuser_new", last_hu, 128'h9);
        chk("t6_pkt_len_new", last_len, 16'd16);

        // Random packets with random gaps and backpressure
        tap_mode = 1;
        for (int p = 0; p < 30; p++) begin
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++) begin
                n = $urandom_range(0, 8);
                k = 8'((16'd1 << n) - 16'd1);
                send({$urandom, $urandom}, k, {$urandom, $urandom, $urandom, $urandom}, i == nb - 1);
                idle($urandom_range(0, 1));
            end
            idle($urandom_range(0, 2));
        end
        tap_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_header_extractor.md
Name: axis_header_extractor

Overview:
- Sits directly downstream of the AXIS data width converter and consumes its narrow resized stream.
- Passes every beat through unchanged via a registered skid stage.
- Captures the first HEADER_BEATS beats of each packet into a wide header vector with a one-cycle valid pulse.
- Reports each packet's byte length at packet end, for the preprocessor's field-matching logic.

Parameters:
- TDATA_WIDTH, 64, stream data width in bits (multiple of 8).
- TUSER_WIDTH, 128, sideband width.
- HEADER_BEATS, 2, beats captured per packet (>=1).
- LEN_WIDTH, 16, packet byte-count width.

Ports:
- axis_aclk  in  1  clock.
- axis_resetn  in  1  asynchronous active-low reset.
- axis_resize_tdata  in  TDATA_WIDTH  input data.
- axis_resize_tkeep  in  TDATA_WIDTH/8  input byte enables, contiguous from LSB.
- axis_resize_tuser  in  TUSER_WIDTH  input sideband.
- axis_resize_tvalid  in  1  input valid.
- axis_resize_tready  out  1  input ready.
- axis_resize_tlast  in  1  input end of packet.
- axis_tap_tdata / tkeep / tuser / tlast  out  as input widths  pass-through beat.
- axis_tap_tvalid  out  1  output valid.
- axis_tap_tready  in  1  output ready.
- header_tdata  out  HEADER_BEATS*TDATA_WIDTH  captured header; beat k at bits [k*TDATA_WIDTH +: TDATA_WIDTH].
- header_tkeep  out  HEADER_BEATS*TDATA_WIDTH/8  byte enables of the captured header.
- header_tuser  out  TUSER_WIDTH  tuser of the packet's first beat.
- header_short  out  1  packet ended before HEADER_BEATS beats.
- header_valid  out  1  one-cycle pulse: header fields valid.
- pkt_len  out  LEN_WIDTH  packet byte count.
- pkt_len_valid  out  1  one-cycle pulse: pkt_len valid.

Behaviour:
- Reset (asynchronous assert, synchronous release): every output register and both skid entries clear to 0; axis_resize_tready = 0 during reset and 1 on the first cycle after release; FSM enters IDLE; beat and byte counters clear to 0.
- Pass-through:
  - Two-entry skid buffer; a beat accepted (tvalid & tready) in cycle N appears on the tap no earlier than N+1.
  - axis_resize_tready is registered and equals "skid has a free entry".
  - Full throughput: 1 beat/cycle when axis_tap_tready is held high.
  - All fields are forwarded bit-exact. No beat is dropped or duplicated.
  - axis_tap_tvalid never deasserts without a handshake.
- FSM (advances only on input handshakes):
  - IDLE: on a handshake, clear the header vector, write beat 0, latch header_tuser, beat_cnt = 1.
    - tlast on that beat: emit both pulses, stay in IDLE.
    - HEADER_BEATS == 1: emit header, go to PAYLOAD.
    - Otherwise: go to HEADER.
  - HEADER: on a handshake, write the beat at index beat_cnt, then beat_cnt++.
    - beat_cnt reaches HEADER_BEATS: emit header, go to PAYLOAD (or IDLE if tlast).
    - tlast first: emit with header_short = 1, go to IDLE.
  - PAYLOAD: beats are counted only; tlast returns the FSM to IDLE.
- Header capture:
  - Unfilled beats of header_tdata / header_tkeep read as 0.
  - header_valid pulses exactly one cycle, the cycle after the handshake of the completing beat.
  - Header outputs hold their values until the next packet's first handshake.
  - No backpressure on header_valid or pkt_len_valid; the consumer must sample the pulse.
- Length:
  - byte_cnt accumulates popcount(tkeep) on every handshake.
  - Saturates at 2^LEN_WIDTH-1; never wraps.
  - pkt_len_valid pulses one cycle after the tlast handshake; pkt_len holds until the next tlast.
  - The counter restarts at 0 for the next packet; a back-to-back first beat in the following cycle is counted correctly.
- Simultaneous events: header_valid and pkt_len_valid may pulse in the same cycle (short packet, or packet of exactly HEADER_BEATS beats).
- A handshake with tkeep = 0 is legal: it counts as a beat and adds 0 bytes.
- Reset mid-packet: the partial packet is discarded, no pulses are emitted for it, and the next beat after release is treated as a first beat.

Test Plan (defaults unless stated):
- 3-beat packet, tkeep FF,FF,0F, data 0x11..,0x22..,0x33.., tuser 0xAB on beat 0, tap_tready=1:
  - Tap outputs identical beats 1 cycle late.
  - header_tdata = {0x22..,0x11..}, header_tkeep = 0xFFFF, header_tuser = 0xAB, header_short = 0.
  - header_valid the cycle after beat 1; pkt_len = 20 the cycle after beat 2.
- 1-beat packet, tkeep 07, tlast:
  - header_valid and pkt_len_valid in the same cycle.
  - header_short = 1, header_tkeep = 0x0007, pkt_len = 3.
- Tap backpressure: tap_tready toggles 1,0,0,1 during a 6-beat packet:
  - axis_resize_tready drops within 1 cycle after the skid fills.
  - All 6 beats are delivered in order; pkt_len = 48.
- Back-to-back packets of 2 and 4 beats, no idle cycles:
  - Two header pulses, each one cycle after the handshake of its packet's second beat.
  - pkt_len values 16 then 32; the second header_tuser comes from packet 2.
- LEN_WIDTH = 8, 40-beat full packet:
  - pkt_len saturates at 255.
- Reset asserted asynchronously during beat 1 of a packet:
  - All outputs are 0 immediately.
  - A new 2-beat packet after release yields a correct header and pkt_len = 16, with no stale pulse.
